// File: rtl/br_pkg.sv
// Shared branch-resolve definitions: compare op codes, predictor states and
// the 2-bit saturating predictor update.
package br_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LTZ = 3'b010;
  localparam logic [2:0] BR_GEZ = 3'b011;
  localparam logic [2:0] BR_LEZ = 3'b100;
  localparam logic [2:0] BR_GTZ = 3'b101;
  localparam logic [2:0] BR_LT  = 3'b110;
  localparam logic [2:0] BR_LTU = 3'b111;

  localparam logic [1:0] PRED_SNT = 2'b00;
  localparam logic [1:0] PRED_WNT = 2'b01;
  localparam logic [1:0] PRED_WT  = 2'b10;
  localparam logic [1:0] PRED_ST  = 2'b11;

  function automatic logic [1:0] pred_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != PRED_ST) nxt = state + 2'd1;
    end else begin
      if (state != PRED_SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: eight compare modes on two operands.
module branch_cond
  import br_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             cond
);

  logic d1_neg;
  logic d1_zero;

  always_comb begin
    d1_neg  = d1[WIDTH-1];
    d1_zero = (d1 == '0);
    cond    = 1'b0;
    case (op)
      BR_EQ:   cond = (d1 == d2);
      BR_NE:   cond = (d1 != d2);
      BR_LTZ:  cond = d1_neg;
      BR_GEZ:  cond = ~d1_neg;
      BR_LEZ:  cond = d1_neg | d1_zero;
      BR_GTZ:  cond = ~d1_neg & ~d1_zero;
      BR_LT:   cond = ($signed(d1) < $signed(d2));
      BR_LTU:  cond = (d1 < d2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage with registered result, 2-bit predictor table and a
// saturating mispredict counter. IF reads the table, ID/EX resolves and updates.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             stall,
  input  logic             res_valid,
  input  logic [2:0]       res_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_pred,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [1:0]       pred_table [DEPTH];
  logic             cond;
  logic             mispredict;
  logic             do_resolve;
  logic [CNT_W-1:0] cnt_one;

  branch_cond #(
    .WIDTH(WIDTH)
  ) u_cond (
    .op  (res_op),
    .d1  (data1),
    .d2  (data2),
    .cond(cond)
  );

  assign cnt_one      = {{(CNT_W-1){1'b0}}, 1'b1};
  assign do_resolve   = res_valid & ~stall;
  assign mispredict   = res_valid & (cond != res_pred);
  // Read is from the registered table, so a same-cycle update is not yet visible.
  assign lookup_taken = pred_table[lookup_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      mispredict_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pred_table[i] <= PRED_WNT;
      end
    end else if (!stall) begin
      out_valid      <= res_valid;
      out_taken      <= res_valid & cond;
      out_mispredict <= mispredict;
      if (mispredict && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + cnt_one;
      end
      if (do_resolve) begin
        pred_table[res_idx] <= pred_next(pred_table[res_idx], cond);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; a second instance with a
// 2-bit counter covers counter saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  lookup_idx;
  logic        lookup_taken;
  logic        stall;
  logic        res_valid;
  logic [2:0]  res_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  res_idx;
  logic        res_pred;
  logic        out_valid;
  logic        out_taken;
  logic        out_mispredict;
  logic [15:0] mispredict_cnt;

  logic        s_lookup_taken;
  logic        s_out_valid;
  logic        s_out_taken;
  logic        s_out_mispredict;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve_unit #(
    .WIDTH(32), .DEPTH(16), .IDX_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .lookup_idx(lookup_idx), .lookup_taken(lookup_taken),
    .stall(stall), .res_valid(res_valid), .res_op(res_op), .data1(data1), .data2(data2),
    .res_idx(res_idx), .res_pred(res_pred), .out_valid(out_valid), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_unit #(
    .WIDTH(32), .DEPTH(16), .IDX_W(4), .CNT_W(2)
  ) dut_small (
    .clk(clk), .reset(reset), .lookup_idx(lookup_idx), .lookup_taken(s_lookup_taken),
    .stall(stall), .res_valid(res_valid), .res_op(res_op), .data1(data1), .data2(data2),
    .res_idx(res_idx), .res_pred(res_pred), .out_valid(s_out_valid), .out_taken(s_out_taken),
    .out_mispredict(s_out_mispredict), .mispredict_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] idx, input logic pred);
    res_valid = 1'b1;
    res_op    = op;
    data1     = a;
    data2     = b;
    res_idx   = idx;
    res_pred  = pred;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic t, input logic m,
                            input logic [15:0] c);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".taken"}, {31'd0, out_taken}, {31'd0, t});
    check({tag, ".mis"}, {31'd0, out_mispredict}, {31'd0, m});
    check({tag, ".cnt"}, {16'd0, mispredict_cnt}, {16'd0, c});
  endtask

  logic       sweep_exp [8];

  initial begin
    reset = 1'b1; stall = 1'b0; res_valid = 1'b0; res_op = 3'd0;
    data1 = '0; data2 = '0; res_idx = '0; res_pred = 1'b0; lookup_idx = '0;
    sweep_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    #23;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset.lookup", {31'd0, lookup_taken}, 32'd0);
    reset = 1'b0;
    tick();

    // Scenario 1: EQ taken, predicted not-taken
    resolve(3'b000, 32'h1234_5678, 32'h1234_5678, 4'd0, 1'b0);
    tick();
    check_outs("s1", 1'b1, 1'b1, 1'b1, 16'd1);
    idle();
    tick();
    check_outs("s1.idle", 1'b0, 1'b0, 1'b0, 16'd1);

    // Scenario 2: op sweep, d1=-1, d2=1, pred 0 (4 taken -> 4 mispredicts)
    for (int i = 0; i < 8; i++) begin
      resolve(3'(i), 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1'b0);
      tick();
      check($sformatf("s2.op%0d", i), {31'd0, out_taken}, {31'd0, sweep_exp[i]});
    end
    idle();
    tick();
    check("s2.cnt", {16'd0, mispredict_cnt}, 32'd5);

    // Scenario 3: idx 3 taken three times, read-before-write on lookup
    lookup_idx = 4'd3;
    #1;
    check("s3.init", {31'd0, lookup_taken}, 32'd0);
    resolve(3'b000, 32'd0, 32'd0, 4'd3, 1'b1);
    #1;
    check("s3.same_cycle", {31'd0, lookup_taken}, 32'd0);
    tick();
    check("s3.after1", {31'd0, lookup_taken}, 32'd1);
    tick();
    tick();
    check("s3.after3", {31'd0, lookup_taken}, 32'd1);
    // one not-taken from saturated 11 stays predicted-taken, second drops to 01
    resolve(3'b001, 32'd0, 32'd0, 4'd3, 1'b1);
    tick();
    check("s3.nt1", {31'd0, lookup_taken}, 32'd1);
    tick();
    check("s3.nt2", {31'd0, lookup_taken}, 32'd0);
    idle();
    tick();
    check("s3.cnt", {16'd0, mispredict_cnt}, 32'd7);

    // Scenario 4: stall holds outputs, table and counter
    lookup_idx = 4'd5;
    resolve(3'b000, 32'd7, 32'd7, 4'd5, 1'b0);
    tick();
    check_outs("s4.pre", 1'b1, 1'b1, 1'b1, 16'd8);
    check("s4.pre.lookup", {31'd0, lookup_taken}, 32'd1);
    stall = 1'b1;
    resolve(3'b001, 32'd7, 32'd7, 4'd5, 1'b1);
    tick();
    tick();
    check_outs("s4.stall", 1'b1, 1'b1, 1'b1, 16'd8);
    check("s4.stall.lookup", {31'd0, lookup_taken}, 32'd1);
    stall = 1'b0;
    tick();
    check_outs("s4.release", 1'b1, 1'b0, 1'b1, 16'd9);
    check("s4.release.lookup", {31'd0, lookup_taken}, 32'd0);
    idle();
    tick();

    // Scenario 5: 2-bit counter saturates
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    check("s5.reset.cnt", {30'd0, s_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      resolve(3'b000, 32'd1, 32'd1, 4'd0, 1'b0);
      tick();
      check($sformatf("s5.cnt%0d", i + 1), {30'd0, s_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("s5.main.cnt", {16'd0, mispredict_cnt}, 32'd5);
    lookup_idx = 4'd0;
    #1;
    check("s5.lookup0", {31'd0, lookup_taken}, 32'd1);

    // Scenario 6: async reset mid-resolve, then scenario 1 again
    resolve(3'b000, 32'h1234_5678, 32'h1234_5678, 4'd0, 1'b0);
    tick();
    check("s6.pre.mis", {31'd0, out_mispredict}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_outs("s6.reset", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      lookup_idx = 4'(i);
      #0.1;
      check($sformatf("s6.table%0d", i), {31'd0, lookup_taken}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_outs("s6.post", 1'b1, 1'b1, 1'b1, 16'd1);
    idle();
    tick();
    check_outs("s6.idle", 1'b0, 1'b0, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
